// File: rtl/uart_tx_frame.sv
// UART transmitter: configurable data width, optional parity, 1-2 stops.
// A one-entry holding register lets the next character queue behind the frame.
module uart_tx_frame #(
  parameter int CLK_PER_BIT = 16,
  parameter int DATA_W      = 8,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam int CW    = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam int NBITS = 1 + DATA_W + PARITY_EN + STOP_BITS;
  localparam int BW    = $clog2(NBITS);

  localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam bit            PAR_ON    = (PARITY_EN != 0);
  localparam bit            PAR_ODD   = (PARITY_ODD != 0);

  if (CLK_PER_BIT < 1) begin : g_bad_cpb
    $error("uart_tx_frame: CLK_PER_BIT must be >= 1");
  end
  if (DATA_W < 5 || DATA_W > 9) begin : g_bad_dw
    $error("uart_tx_frame: DATA_W must be 5..9");
  end
  if (PARITY_EN != 0 && PARITY_EN != 1) begin : g_bad_pe
    $error("uart_tx_frame: PARITY_EN must be 0 or 1");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_po
    $error("uart_tx_frame: PARITY_ODD must be 0 or 1");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_sb
    $error("uart_tx_frame: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [CW-1:0]     r_cnt;
  logic [BW-1:0]     r_bit;
  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] r_shift;
  logic              r_hold_full;
  logic              r_par;

  logic w_bit_end;
  logic w_last;
  logic w_load;
  logic w_accept;

  assign w_bit_end = (r_cnt == CNT_MAX);
  assign w_last    = (r_state == S_STOP) && w_bit_end && (r_bit == STOP_LAST);
  // Reload either from idle or on the final stop cycle for gapless frames
  assign w_load    = r_hold_full && ((r_state == S_IDLE) || w_last);
  assign w_accept  = valid_o && ready_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (r_hold_full) w_next = S_START;
      S_START: if (w_bit_end) w_next = S_DATA;
      S_DATA:
        if (w_bit_end && r_bit == DATA_LAST)
          w_next = PAR_ON ? S_PAR : S_STOP;
      S_PAR:   if (w_bit_end) w_next = S_STOP;
      S_STOP:
        if (w_last)
          w_next = r_hold_full ? S_START : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    tx_o         = 1'b1;
    busy_o       = (r_state != S_IDLE);
    frame_done_o = w_last;
    valid_o      = !reset_i && !r_hold_full;
    case (r_state)
      S_START: tx_o = 1'b0;
      S_DATA:  tx_o = r_shift[0];
      S_PAR:   tx_o = r_par;
      default: tx_o = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_par       <= 1'b0;
      r_cnt       <= '0;
      r_bit       <= '0;
    end else begin
      if (w_accept) r_hold <= tx_data_i;

      if (w_load)        r_hold_full <= 1'b0;
      else if (w_accept) r_hold_full <= 1'b1;

      if (w_load) begin
        r_shift <= r_hold;
        r_par   <= (^r_hold) ^ PAR_ODD;
        r_cnt   <= '0;
        r_bit   <= '0;
      end else if (r_state != S_IDLE) begin
        if (w_bit_end) begin
          r_cnt <= '0;
          r_bit <= (w_next != r_state) ? '0 : r_bit + 1'b1;
          if (r_state == S_DATA) r_shift <= r_shift >> 1;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: four configurations against a
// cycle-timeline frame model, directed and random characters.
module tb_uart_tx_frame;

  localparam int N = 4;

  int cpb [N] = '{4, 4, 3, 1};
  int dw  [N] = '{8, 8, 7, 9};
  int pe  [N] = '{0, 1, 0, 1};
  int po  [N] = '{0, 0, 0, 1};
  int sb  [N] = '{1, 1, 2, 2};

  logic       clk = 1'b0;
  logic       rst;
  logic       s_ready [N];
  logic [8:0] s_data  [N];
  logic       s_valid [N];
  logic       s_tx    [N];
  logic       s_busy  [N];
  logic       s_done  [N];

  int n_vec = 0;
  int n_err = 0;

  logic [8:0] cq [$];

  always #5 clk = ~clk;

  uart_tx_frame #(
    .CLK_PER_BIT(4), .DATA_W(8), .PARITY_EN(0),
    .PARITY_ODD(0), .STOP_BITS(1)
  ) u_a (
    .clk_i(clk), .reset_i(rst),
    .tx_data_i(s_data[0][7:0]), .ready_i(s_ready[0]),
    .valid_o(s_valid[0]), .tx_o(s_tx[0]),
    .busy_o(s_busy[0]), .frame_done_o(s_done[0])
  );

  uart_tx_frame #(
    .CLK_PER_BIT(4), .DATA_W(8), .PARITY_EN(1),
    .PARITY_ODD(0), .STOP_BITS(1)
  ) u_b (
    .clk_i(clk), .reset_i(rst),
    .tx_data_i(s_data[1][7:0]), .ready_i(s_ready[1]),
    .valid_o(s_valid[1]), .tx_o(s_tx[1]),
    .busy_o(s_busy[1]), .frame_done_o(s_done[1])
  );

  uart_tx_frame #(
    .CLK_PER_BIT(3), .DATA_W(7), .PARITY_EN(0),
    .PARITY_ODD(0), .STOP_BITS(2)
  ) u_c (
    .clk_i(clk), .reset_i(rst),
    .tx_data_i(s_data[2][6:0]), .ready_i(s_ready[2]),
    .valid_o(s_valid[2]), .tx_o(s_tx[2]),
    .busy_o(s_busy[2]), .frame_done_o(s_done[2])
  );

  uart_tx_frame #(
    .CLK_PER_BIT(1), .DATA_W(9), .PARITY_EN(1),
    .PARITY_ODD(1), .STOP_BITS(2)
  ) u_d (
    .clk_i(clk), .reset_i(rst),
    .tx_data_i(s_data[3]), .ready_i(s_ready[3]),
    .valid_o(s_valid[3]), .tx_o(s_tx[3]),
    .busy_o(s_busy[3]), .frame_done_o(s_done[3])
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int flen(int k);
    return cpb[k] * (1 + dw[k] + pe[k] + sb[k]);
  endfunction

  // Serial bit b of a frame: start, data LSB first, parity, stops
  function automatic logic fbit(int k, logic [8:0] c, int b);
    int ones;
    ones = 0;
    if (b == 0) return 1'b0;
    if (b <= dw[k]) return c[b-1];
    if (pe[k] != 0 && b == dw[k] + 1) begin
      for (int i = 0; i < dw[k]; i++) ones += int'(c[i]);
      return ((ones + po[k]) % 2) == 1;
    end
    return 1'b1;
  endfunction

  function automatic logic [8:0] rnd_char(int k);
    logic [8:0] m;
    m = 9'h1FF >> (9 - dw[k]);
    return 9'($urandom) & m;
  endfunction

  // Model: one holding slot plus the interval of the current frame.
  // fixed>0 stops after that many cycles, else runs until quiescent.
  task automatic run(input int k, input logic [8:0] chars[$],
                     input int pct, input int fixed, input string tag);
    logic [8:0] q [$];
    logic [8:0] m_hc, m_cc;
    bit   m_hold;
    int   m_start, m_end, fl, cyc, nd_dut, nd_exp, nfr;
    logic e_tx, e_busy, e_done, e_valid;
    bit   rdy;
    q = chars;
    m_hold = 0; m_hc = '0; m_cc = '0;
    m_start = 0; m_end = -1; fl = flen(k);
    cyc = 0; nd_dut = 0; nd_exp = 0; nfr = 0;
    while (1) begin
      if (fixed > 0 && cyc >= fixed) break;
      if (fixed == 0 && q.size() == 0 && !m_hold && cyc > m_end) break;
      if (cyc >= 5000) begin
        chk({tag, " timeout"}, 32'd1, 32'd0);
        break;
      end
      @(negedge clk);
      if (cyc >= m_start && cyc <= m_end) begin
        e_tx   = fbit(k, m_cc, (cyc - m_start) / cpb[k]);
        e_busy = 1'b1;
        e_done = (cyc == m_end);
      end else begin
        e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
      end
      e_valid = !m_hold;
      chk($sformatf("%s tx c%0d", tag, cyc), 32'(s_tx[k]), 32'(e_tx));
      chk($sformatf("%s busy c%0d", tag, cyc), 32'(s_busy[k]), 32'(e_busy));
      chk($sformatf("%s done c%0d", tag, cyc), 32'(s_done[k]), 32'(e_done));
      chk($sformatf("%s valid c%0d", tag, cyc), 32'(s_valid[k]), 32'(e_valid));
      if (s_done[k] === 1'b1) nd_dut++;
      if (e_done) nd_exp++;
      rdy = (q.size() > 0) && ($urandom_range(99) < pct);
      s_ready[k] = rdy;
      s_data[k]  = (e_valid && rdy) ? q[0] : 9'($urandom);
      if (m_hold && cyc >= m_end) begin
        m_cc = m_hc; m_start = cyc + 1; m_end = cyc + fl;
        m_hold = 0; nfr++;
      end else if (e_valid && rdy) begin
        m_hc = q.pop_front();
        m_hold = 1;
      end
      cyc++;
    end
    s_ready[k] = 1'b0;
    chk({tag, " done count"}, 32'(nd_dut), 32'(nd_exp));
    if (fixed == 0) chk({tag, " frames"}, 32'(nfr), 32'(chars.size()));
  endtask

  initial begin
    rst = 1'b1;
    for (int k = 0; k < N; k++) begin
      s_ready[k] = 1'b0;
      s_data[k]  = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("reset tx%0d", k), 32'(s_tx[k]), 32'd1);
      chk($sformatf("reset busy%0d", k), 32'(s_busy[k]), 32'd0);
      chk($sformatf("reset done%0d", k), 32'(s_done[k]), 32'd0);
      chk($sformatf("reset valid%0d", k), 32'(s_valid[k]), 32'd0);
    end
    rst = 1'b0;

    cq.delete(); cq.push_back(9'h0A5);
    run(0, cq, 100, 0, "a5");
    cq.delete(); cq.push_back(9'h007);
    run(1, cq, 100, 0, "par_even07");
    cq.delete(); cq.push_back(9'h000);
    run(3, cq, 100, 0, "par_odd00");
    cq.delete(); cq.push_back(9'h041);
    run(2, cq, 100, 0, "w7s2");
    cq.delete(); cq.push_back(9'h055); cq.push_back(9'h0AA);
    run(0, cq, 100, 0, "b2b");

    // Abort a frame of zeros with another character queued behind it
    cq.delete(); cq.push_back(9'h000); cq.push_back(9'h034);
    run(0, cq, 100, 15, "abort");
    chk("abort pre tx", 32'(s_tx[0]), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("abort async tx", 32'(s_tx[0]), 32'd1);
    chk("abort async busy", 32'(s_busy[0]), 32'd0);
    chk("abort async done", 32'(s_done[0]), 32'd0);
    chk("abort async valid", 32'(s_valid[0]), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("abort held tx", 32'(s_tx[0]), 32'd1);
    rst = 1'b0;
    cq.delete(); cq.push_back(9'h03C);
    run(0, cq, 100, 0, "post_rst");

    for (int k = 0; k < N; k++) begin
      for (int r = 0; r < 3; r++) begin
        cq.delete();
        for (int i = 0; i < 1 + $urandom_range(4); i++)
          cq.push_back(rnd_char(k));
        run(k, cq, (r == 1) ? 30 : 100, 0,
            $sformatf("rnd k%0d r%0d", k, r));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 transmitter. Adds a configurable data width, optional even/odd parity and 1 or 2 stop bits. A one-entry holding register lets the upstream source queue the next character while the current frame shifts out, so consecutive frames leave with no idle gap. Sits between a byte or character source (CPU register, FIFO) and the serial TX pin.

Parameters:
CLK_PER_BIT, 16, clk_i cycles per serial bit; legal range >= 1.
DATA_W, 8, data bits per frame; legal range 5..9.
PARITY_EN, 0, 1 appends a parity bit after the data bits.
PARITY_ODD, 0, 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
clk_i  input  1  clock; all state changes on the rising edge.
reset_i  input  1  asynchronous, active-high reset.
tx_data_i  input  DATA_W  character to send, LSB transmitted first.
ready_i  input  1  source has a character on tx_data_i.
valid_o  output  1  holding register empty; block can accept a character.
tx_o  output  1  serial line; idles high.
busy_o  output  1  a frame is being shifted out.
frame_done_o  output  1  one-cycle pulse on the last cycle of the last stop bit.

Behaviour:
- Reset (async assert, sync release): tx_o=1, busy_o=0, frame_done_o=0, holding register empty, bit and cycle counters 0. valid_o=0 while reset_i=1.
- valid_o = !reset_i && !hold_full.
- Accept: valid_o && ready_i at a rising edge captures tx_data_i into the holding register and sets hold_full. A held ready_i with valid_o low has no effect and the data must stay stable.
- Frame order: start (0), data[0..DATA_W-1], parity bit if enabled, then STOP_BITS ones. Each bit lasts exactly CLK_PER_BIT cycles.
- Frame length: FL = CLK_PER_BIT*(1+DATA_W+PARITY_EN+STOP_BITS) cycles.
- Parity: even mode gives XOR of the data bits; odd mode gives its inverse.
- States:
  - IDLE: tx_o=1, busy_o=0. If hold_full, load the shifter from the holding register, clear hold_full, go to START.
  - START, DATA, PARITY, STOP: advance when the cycle counter reaches CLK_PER_BIT-1, then reset the counter to 0.
- Load latency: a character accepted at edge N into an empty holding register with the shifter idle drives tx_o=0 from edge N+1. valid_o goes 0 at N and back to 1 at N+1.
- Back-to-back:
  - On the last cycle of the last stop bit, frame_done_o=1.
  - If hold_full at that point, the shifter reloads at that edge and the next start bit begins immediately, with no idle cycles. busy_o stays 1 and hold_full clears.
  - Otherwise the block returns to IDLE.
- A character may be accepted at any point in a frame, including the cycle the holding register empties; hold_full and valid_o resolve correctly.
- CLK_PER_BIT=1: each bit lasts one cycle and all rules above still hold.
- Reset mid-frame: tx_o goes to 1 immediately (asynchronously), the frame is aborted, the holding register is discarded, no frame_done_o pulse occurs.
- Counter widths are derived from $clog2 of CLK_PER_BIT and of the total bit count; no wrap-around is possible within legal parameters.
- Illegal parameter values cause an elaboration-time error.

Test Plan:
- CLK_PER_BIT=4, DATA_W=8, no parity, 1 stop; send 0xA5 -> tx_o bit sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total); frame_done_o pulses exactly once at cycle 40; busy_o falls after it.
- PARITY_EN=1, PARITY_ODD=0, send 0x07 -> parity bit 1. With PARITY_ODD=1, send 0x00 -> parity bit 1. Frame is 44 cycles at CLK_PER_BIT=4.
- DATA_W=7, STOP_BITS=2, CLK_PER_BIT=3; send 0x41 -> 0, 1,0,0,0,0,0,1, 1,1 (30 cycles); data bit 7 is never driven.
- Back-to-back, CLK_PER_BIT=4: ready_i held with 0x55 then 0xAA.
  - 80 contiguous frame cycles, no idle high between frames.
  - Second character accepted at cycle 1 of the first frame; valid_o stays low until the first frame's last cycle.
  - Two frame_done_o pulses, 40 cycles apart.
- Assert reset_i at cycle 13 of a frame -> tx_o=1 in the same cycle (no edge needed), busy_o=0, queued character lost. After release, a new character 0x3C transmits correctly.
- ready_i asserted while valid_o=0 with changing tx_data_i -> no capture; only the character present when valid_o && ready_i is transmitted.
